// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// FIFO_ARB_SRC_TAG_EN selects whether the requester index is prepended to each FIFO word.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Index width that never collapses to zero, even for tiny requester counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

`ifdef FIFO_ARB_SRC_TAG_EN
  localparam bit SRC_TAG_EN = 1'b1;
`else
  localparam bit SRC_TAG_EN = 1'b0;
`endif

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   rr_ptr,
  output logic               any_req,
  output logic [SRC_W-1:0]   pick
);

  always_comb begin
    int   idx;
    logic found;
    any_req = |req;
    pick    = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        pick  = SRC_W'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one sync FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_SRC_TAG_EN to prepend the owning requester index to every FIFO word.
//
// state | meaning
// IDLE  | no owner; picks the next requester when arb_en and any valid
// BURST | grant_id owns the write port until last beat or MAX_BURST beats
module sync_fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int SRC_W      = clog2_min1(NUM_REQ),
  localparam int DW_OUT     = SRC_TAG_EN ? DATA_WIDTH + SRC_W : DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DW_OUT-1:0]             fifo_wr_data,
  input  logic                          fifo_full,
  output logic                          grant_valid,
  output logic [SRC_W-1:0]              grant_id
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state, state_nxt;
  logic [SRC_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [SRC_W-1:0] gid, gid_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

  logic                  any_req;
  logic [SRC_W-1:0]      pick;
  logic [DATA_WIDTH-1:0] payload;
  logic                  xfer;
  logic                  last_beat;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_rr_pick (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .any_req (any_req),
    .pick    (pick)
  );

  assign payload     = req_data[int'(gid)*DATA_WIDTH +: DATA_WIDTH];
  assign xfer        = (state == BURST) && req_valid[gid] && !fifo_full;
  assign last_beat   = req_last[gid] || (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign grant_valid = (state == BURST);
  assign grant_id    = gid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gid      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      gid      <= gid_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    gid_nxt      = gid;
    beat_cnt_nxt = beat_cnt;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    unique case (state)
      IDLE: begin
        if (arb_en && any_req) begin
          gid_nxt   = pick;
          state_nxt = BURST;
        end
      end
      BURST: begin
        req_ready[gid] = !fifo_full;
        if (xfer) begin
          fifo_wr_en = 1'b1;
`ifdef FIFO_ARB_SRC_TAG_EN
          fifo_wr_data = {gid, payload};
`else
          fifo_wr_data = payload;
`endif
          if (last_beat) begin
            // grant_id reads 0 while idle, so the owner is cleared at burst end
            state_nxt    = IDLE;
            rr_ptr_nxt   = (int'(gid) == NUM_REQ - 1) ? '0 : gid + SRC_W'(1);
            gid_nxt      = '0;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
